// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: instruction field layout, funct codes
// and the decoded-instruction struct.
package alu_issue_pkg;

  localparam int FUNCT_W     = 5;
  localparam int REG_AW      = 5;
  localparam int INSTR_IMM_W = 11;

  localparam int FUNCT_LSB   = 27;
  localparam int RD_LSB      = 22;
  localparam int RS_LSB      = 17;
  localparam int RT_LSB      = 12;
  localparam int IMM_SEL_BIT = 11;
  localparam int IMM_LSB     = 0;

  localparam logic [FUNCT_W-1:0] FN_ADD_S = 5'b00000;
  localparam logic [FUNCT_W-1:0] FN_SUB_S = 5'b00001;
  localparam logic [FUNCT_W-1:0] FN_ADD_U = 5'b00010;
  localparam logic [FUNCT_W-1:0] FN_SUB_U = 5'b00011;
  localparam logic [FUNCT_W-1:0] FN_AND   = 5'b00100;
  localparam logic [FUNCT_W-1:0] FN_OR    = 5'b00101;
  localparam logic [FUNCT_W-1:0] FN_SHL   = 5'b00110;
  localparam logic [FUNCT_W-1:0] FN_SHR   = 5'b00111;
  localparam logic [FUNCT_W-1:0] FN_SLT   = 5'b01000;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [FUNCT_W-1:0]     funct;
    logic [REG_AW-1:0]      rd;
    logic [REG_AW-1:0]      rs;
    logic [REG_AW-1:0]      rt;
    logic                   imm_sel;
    logic [INSTR_IMM_W-1:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [31:0] w);
    instr_t d;
    d.funct   = w[FUNCT_LSB +: FUNCT_W];
    d.rd      = w[RD_LSB +: REG_AW];
    d.rs      = w[RS_LSB +: REG_AW];
    d.rt      = w[RT_LSB +: REG_AW];
    d.imm_sel = w[IMM_SEL_BIT];
    d.imm     = w[IMM_LSB +: INSTR_IMM_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the ALU issue stage: three combinational read ports (rs, rt, debug),
// one synchronous write port, entry 0 hardwired to zero.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs_addr,
  output logic [XLEN-1:0] rs_data,
  input  logic [AW-1:0]   rt_addr,
  output logic [XLEN-1:0] rt_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_reg [NREGS];
  logic [AW-1:0]   rd_addr  [3];
  logic [XLEN-1:0] rd_data  [3];

  // Entry 0 is never written, so it keeps its reset value; reads mask it anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (wr_addr != AW'(REG_ZERO))) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;
  assign rd_addr[2] = dbg_addr;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_data[gi] = (rd_addr[gi] == AW'(REG_ZERO)) ? '0 : regs_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs_data  = rd_data[0];
  assign rt_data  = rd_data[1];
  assign dbg_data = rd_data[2];

endmodule

// File: rtl/alu_issue_stage.sv
// Single-issue feeder for the 32-bit ALU with operand read, issue register and write-back.
// Optional macro ALU_ISSUE_FWD_EN: forward alu_out to dependent operands instead of stalling.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IMM_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            hold,
  output logic [4:0]      alu_funct,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     retire_cnt,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  instr_t          dec;
  logic            adv;
  logic            accept;
  logic            commit;
  logic            rs_match;
  logic            rt_match;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] opa_next;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] opb_next;
  logic [XLEN-1:0] imm_ext;

  logic            issue_valid_reg;
  logic [4:0]      issue_rd_reg;
  logic [4:0]      issue_funct_reg;
  logic [XLEN-1:0] issue_a_reg;
  logic [XLEN-1:0] issue_b_reg;
  logic            wb_valid_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic [31:0]     retire_cnt_reg;
  logic [31:0]     retire_cnt_next;

  assign dec     = decode_instr(in_instr);
  assign adv     = !hold;
  assign commit  = issue_valid_reg && adv;
  assign imm_ext = {{(XLEN-IMM_W){dec.imm[IMM_W-1]}}, dec.imm[IMM_W-1:0]};

  // A match against rd=0 never counts: r0 reads zero regardless of what is in flight.
  assign rs_match = issue_valid_reg && (issue_rd_reg != REG_ZERO) && (dec.rs == issue_rd_reg);
  assign rt_match = issue_valid_reg && (issue_rd_reg != REG_ZERO) && !dec.imm_sel &&
                    (dec.rt == issue_rd_reg);

`ifdef ALU_ISSUE_FWD_EN
  assign in_ready = !rst && adv;
  assign opa_next = rs_match ? alu_out : rs_data;
  assign rt_val   = rt_match ? alu_out : rt_data;
`else
  // Without forwarding, a dependent instruction waits until the producer has committed.
  assign in_ready = !rst && adv && !(rs_match || rt_match);
  assign opa_next = rs_data;
  assign rt_val   = rt_data;
`endif

  assign opb_next        = dec.imm_sel ? imm_ext : rt_val;
  assign accept          = in_valid && in_ready;
  assign retire_cnt_next = retire_cnt_reg + 32'd1;

  alu_issue_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (dec.rs),
    .rs_data  (rs_data),
    .rt_addr  (dec.rt),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (commit),
    .wr_addr  (issue_rd_reg),
    .wr_data  (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_reg <= 1'b0;
      issue_rd_reg    <= '0;
      issue_funct_reg <= '0;
      issue_a_reg     <= '0;
      issue_b_reg     <= '0;
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= '0;
      wb_data_reg     <= '0;
      retire_cnt_reg  <= '0;
    end else begin
      // On a bubble only the valid bit drops; the ALU operands keep their last values.
      if (adv) begin
        issue_valid_reg <= accept;
        if (accept) begin
          issue_rd_reg    <= dec.rd;
          issue_funct_reg <= dec.funct;
          issue_a_reg     <= opa_next;
          issue_b_reg     <= opb_next;
        end
      end
      wb_valid_reg <= commit;
      if (commit) begin
        wb_rd_reg      <= issue_rd_reg;
        wb_data_reg    <= alu_out;
        retire_cnt_reg <= retire_cnt_next;
      end
    end
  end

  assign alu_funct  = issue_funct_reg;
  assign alu_a      = issue_a_reg;
  assign alu_b      = issue_b_reg;
  assign wb_valid   = wb_valid_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_data    = wb_data_reg;
  assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: an in-order architectural model predicts each
// write-back at issue time; a monitor pops and compares on every wb_valid pulse.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        hold;
  logic [4:0]  alu_funct;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .hold       (hold),
    .alu_funct  (alu_funct),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .retire_cnt (retire_cnt),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    case (f)
      FN_ADD_S, FN_ADD_U: return a + b;
      FN_SUB_S, FN_SUB_U: return a - b;
      FN_AND:             return a & b;
      FN_OR:              return a | b;
      FN_SHL:             return a << b[4:0];
      FN_SHR:             return a >> b[4:0];
      FN_SLT:             return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:            return 32'd0;
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_funct, alu_a, alu_b);

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_r [32];
  int          exp_retire;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] f, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic isel, input logic [10:0] imm);
    return {f, rd, rs, rt, isel, imm};
  endfunction

  // Sequential architectural semantics: each instruction sees all earlier results.
  task automatic model_accept(input logic [31:0] w);
    logic [4:0]  f, rd, rs, rt;
    logic        isel;
    logic [10:0] imm;
    logic [31:0] a, b, res;
    {f, rd, rs, rt, isel, imm} = w;
    a   = (rs == 5'd0) ? 32'd0 : model_r[rs];
    b   = isel ? {{21{imm[10]}}, imm} : ((rt == 5'd0) ? 32'd0 : model_r[rt]);
    res = alu_f(f, a, b);
    if (rd != 5'd0) model_r[rd] = res;
    sb_q.push_back('{rd: rd, data: res});
    $display("ISSUE f=%0d rd=%0d rs=%0d rt=%0d isel=%0d imm=%h exp=%h",
             f, rd, rs, rt, isel, imm, res);
  endtask

  task automatic issue(input logic [31:0] w, input bit rand_hold, output int stalls);
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = w;
    for (int t = 0; t < 64 && !done; t++) begin
      hold = rand_hold ? ($urandom_range(0, 9) == 0) : 1'b0;
      #1;
      if (in_ready) begin
        model_accept(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold     = 1'b0;
        done     = 1'b1;
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout actual=no_accept required=accept_within_64");
      in_valid = 1'b0;
      hold     = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dbg_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic model_clear();
    sb_q.delete();
    for (int i = 0; i < 32; i++) model_r[i] = 32'd0;
    exp_retire = 0;
  endtask

  // Monitor: every committed result must match the oldest outstanding prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected actual=rd%0d:%h required=no_writeback", wb_rd, wb_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          exp_retire++;
          $display("WB rd=%0d data=%h retire=%0d", wb_rd, wb_data, retire_cnt);
          check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          check("wb_data", wb_data, e.data);
          check("retire_cnt", retire_cnt, exp_retire);
        end
      end
    end
  end

  initial begin
    int          st;
    int          exp_stall;
    logic [4:0]  hf;
    logic [31:0] ha, hb;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'd0;
    hold     = 1'b0;
    dbg_addr = 5'd0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_alu_funct", {27'd0, alu_funct}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    dbg_check("rst_dbg_r5", 5'd5, 32'd0);

    // First instruction: operands and two-edge latency
    issue(mk(FN_ADD_U, 5'd1, 5'd0, 5'd0, 1'b1, 11'd5), 1'b0, st);
    check("t1_alu_a", alu_a, 32'd0);
    check("t1_alu_b", alu_b, 32'd5);
    @(negedge clk);
    check("t1_wb_early", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("t1_wb_pulse", {31'd0, wb_valid}, 32'd1);
    idle(1);
    dbg_check("t1_dbg_r1", 5'd1, 32'd5);
    check("t1_retire", retire_cnt, 32'd1);

    // Back-to-back RAW: r1 changes to 7 just before the dependent read
`ifdef ALU_ISSUE_FWD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    issue(mk(FN_ADD_U, 5'd1, 5'd0, 5'd0, 1'b1, 11'd7), 1'b0, st);
    issue(mk(FN_ADD_U, 5'd2, 5'd1, 5'd1, 1'b0, 11'd0), 1'b0, st);
    check("b2b_stalls", st, exp_stall);
    idle(3);
    dbg_check("b2b_dbg_r2", 5'd2, 32'd14);

    // Immediate sign extension
    issue(mk(FN_ADD_U, 5'd3, 5'd0, 5'd0, 1'b1, 11'h7FF), 1'b0, st);
    check("sext_alu_b", alu_b, 32'hFFFF_FFFF);
    idle(3);
    dbg_check("sext_dbg_r3", 5'd3, 32'hFFFF_FFFF);

    // Write to r0 followed by a read of r0
    issue(mk(FN_ADD_U, 5'd0, 5'd0, 5'd0, 1'b1, 11'd7), 1'b0, st);
    issue(mk(FN_OR, 5'd4, 5'd0, 5'd0, 1'b0, 11'd0), 1'b0, st);
    check("r0_alu_a", alu_a, 32'd0);
    idle(3);
    dbg_check("r0_dbg_r0", 5'd0, 32'd0);
    dbg_check("r0_dbg_r4", 5'd4, 32'd0);

    // Hold for three cycles with a valid issue register
    issue(mk(FN_SHL, 5'd5, 5'd1, 5'd0, 1'b1, 11'd2), 1'b0, st);
    hf = alu_funct;
    ha = alu_a;
    hb = alu_b;
    check("hold_alu_a", ha, 32'd7);
    hold     = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(FN_ADD_U, 5'd6, 5'd0, 5'd0, 1'b1, 11'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("hold_alu_funct", {27'd0, alu_funct}, {27'd0, hf});
      check("hold_alu_a", alu_a, ha);
      check("hold_alu_b", alu_b, hb);
      @(posedge clk);
      #1;
    end
    hold     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_no_commit", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("hold_release_commit", {31'd0, wb_valid}, 32'd1);
    idle(2);
    dbg_check("hold_dbg_r5", 5'd5, 32'd28);

    // Reset the cycle after an accept drops the in-flight instruction
    issue(mk(FN_ADD_U, 5'd7, 5'd0, 5'd0, 1'b1, 11'd9), 1'b0, st);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    end
    dbg_check("midrst_dbg_r7", 5'd7, 32'd0);
    dbg_check("midrst_dbg_r1", 5'd1, 32'd0);
    check("midrst_retire", retire_cnt, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 300; n++) begin
      logic [4:0] f;
      f = 5'($urandom_range(0, 9));
      issue(mk(f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               11'($urandom_range(0, 2047))), 1'b1, st);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    hold = 1'b0;
    idle(5);
    check("drain_queue_empty", sb_q.size(), 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_check("final_reg", 5'(r), model_r[r]);
    end
    check("final_retire", retire_cnt, exp_retire);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
